// File: rtl/ysyx_22041207_mul_sched.sv
// ysyx_22041207_mul_sched
// Shares one iterative 64-bit multiplier between two requesters. Ports are
// picked round-robin and one operation is in flight at a time. Each result
// is held until its owner accepts it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no op in flight; grant an eligible port when m_ready=1
// ISSUE | drive m_valid for one cycle with the latched operands
// WAIT  | multiplier busy; capture (and maybe sign-extend) the result
// RESP  | hold the result on the owner's resp port until it is accepted
module ysyx_22041207_mul_sched #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [63:0]      req0_a,
    input  logic [63:0]      req0_b,
    input  logic             req0_word,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req0_kill,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [63:0]      req1_a,
    input  logic [63:0]      req1_b,
    input  logic             req1_word,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic             req1_kill,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [63:0]      resp0_data,
    output logic [TAG_W-1:0] resp0_tag,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [63:0]      resp1_data,
    output logic [TAG_W-1:0] resp1_tag,
    output logic             m_valid,
    output logic [63:0]      m_a,
    output logic [63:0]      m_b,
    input  logic             m_ready,
    input  logic             m_out_valid,
    input  logic [63:0]      m_res
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              prio_q;
    logic              owner_q;
    logic              killed_q;
    logic [63:0]       a_q, b_q, res_q;
    logic              word_q;
    logic [TAG_W-1:0]  tag_q;

    logic              elig0, elig1;
    logic              grant;
    logic              fire;
    logic              owner_kill;
    logic              owner_resp_ready;
    logic [63:0]       res_fmt;

    // Arbitration: a kill masks a same-cycle request; prio breaks ties.
    always_comb begin
        elig0            = req0_valid & ~req0_kill;
        elig1            = req1_valid & ~req1_kill;
        grant            = (elig0 & elig1) ? prio_q : elig1;
        fire             = (state_q == IDLE) & m_ready & (elig0 | elig1);
        req0_ready       = fire & ~grant;
        req1_ready       = fire & grant;
        owner_kill       = owner_q ? req1_kill : req0_kill;
        owner_resp_ready = owner_q ? resp1_ready : resp0_ready;
        res_fmt          = word_q ? {{32{m_res[31]}}, m_res[31:0]} : m_res;
    end

    // Next-state logic; a killed op still finishes the multiplier handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (fire) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  if (m_out_valid) state_d = (killed_q | owner_kill) ? IDLE : RESP;
            RESP:  if (owner_kill | owner_resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, round-robin pointer, owner and kill flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            killed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                prio_q   <= ~grant;
                owner_q  <= grant;
                killed_q <= 1'b0;
            end else if (((state_q == ISSUE) || (state_q == WAIT)) && owner_kill) begin
                killed_q <= 1'b1;
            end
        end
    end

    // Operand capture on fire and result capture when the multiplier finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            word_q <= 1'b0;
            tag_q  <= '0;
            res_q  <= '0;
        end else begin
            if (fire) begin
                a_q    <= grant ? req1_a    : req0_a;
                b_q    <= grant ? req1_b    : req0_b;
                word_q <= grant ? req1_word : req0_word;
                tag_q  <= grant ? req1_tag  : req0_tag;
            end
            if ((state_q == WAIT) && m_out_valid) begin
                res_q <= res_fmt;
            end
        end
    end

    assign m_valid     = (state_q == ISSUE);
    assign m_a         = a_q;
    assign m_b         = b_q;
    assign resp0_valid = (state_q == RESP) & ~owner_q;
    assign resp1_valid = (state_q == RESP) & owner_q;
    assign resp0_data  = res_q;
    assign resp1_data  = res_q;
    assign resp0_tag   = tag_q;
    assign resp1_tag   = tag_q;

endmodule
